// File: rtl/ex_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the iterative mul/div unit.
interface ex_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO result registers.
// Operands run as magnitudes; signs are restored in FIN before the write.
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic             launch;
    logic             fin_exit;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_qr;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign bus.busy = (state != IDLE);

    always_comb begin
        sgn   = ~bus.op[0];
        a_neg = sgn & bus.src_a[WIDTH-1];
        b_neg = sgn & bus.src_b[WIDTH-1];
        a_mag = a_neg ? -bus.src_a : bus.src_a;
        b_mag = b_neg ? -bus.src_b : bus.src_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        fin_exit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    launch = 1'b1;
                    if (bus.op[1] && bus.src_b == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                fin_exit  = !bus.flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
        div_tmp = {acc, qr[WIDTH-1]};
        div_ge  = div_tmp >= {1'b0, opb};
        div_sub = div_tmp[WIDTH-1:0] - opb;
        if (is_div) begin
            step_acc = div_ge ? div_sub : div_tmp[WIDTH-1:0];
            step_qr  = {qr[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_qr  = {mul_sum[0], qr[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -{acc, qr} : {acc, qr};
        q_fix    = neg_q ? -qr : qr;
        r_fix    = neg_r ? -acc : acc;
        if (is_div) begin
            res_hi = r_fix;
            res_lo = q_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc             <= '0;
            qr              <= '0;
            opb             <= '0;
            cnt             <= '0;
            is_div          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dz              <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done        <= fin_exit;
            bus.div_by_zero <= fin_exit & dz;
            if (launch) begin
                acc    <= '0;
                qr     <= a_mag;
                opb    <= b_mag;
                cnt    <= '0;
                is_div <= bus.op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= bus.op[1] & (bus.src_b == '0);
            end else if (state == RUN) begin
                acc <= step_acc;
                qr  <= step_qr;
                cnt <= cnt + 1'b1;
            end
            // A divide by zero leaves the previous HI/LO visible.
            if (fin_exit && !dz) begin
                bus.hi <= res_hi;
                bus.lo <= res_lo;
            end
        end
    end
endmodule
